// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: alignment check, dmem req/ack handshake, load extraction
`ifndef EXC_TYPE_LENGTH
`define EXC_TYPE_LENGTH 5
`endif
`ifndef EXC_TYPE_NONE
`define EXC_TYPE_NONE 5'd0
`endif
`ifndef EXC_TYPE_ADEL
`define EXC_TYPE_ADEL 5'd4
`endif
`ifndef EXC_TYPE_ADES
`define EXC_TYPE_ADES 5'd5
`endif
`ifndef EXC_TYPE_DBE
`define EXC_TYPE_DBE 5'd7
`endif
`ifndef EXC_TYPE_OV
`define EXC_TYPE_OV 5'd12
`endif

module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int EXC_W          = `EXC_TYPE_LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [3:0]       mem_op,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      store_data,
    input  logic [4:0]       dest_reg,
    input  logic [EXC_W-1:0] exc_type_in,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             stall_req,
    output logic             out_valid,
    output logic             out_wen,
    output logic [4:0]       out_dest,
    output logic [31:0]      out_result,
    output logic [EXC_W-1:0] out_exc_type,
    output logic [31:0]      out_bad_vaddr
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [EXC_W-1:0] EXC_NONE = EXC_W'(`EXC_TYPE_NONE);
    localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(`EXC_TYPE_ADEL);
    localparam logic [EXC_W-1:0] EXC_ADES = EXC_W'(`EXC_TYPE_ADES);
    localparam logic [EXC_W-1:0] EXC_DBE  = EXC_W'(`EXC_TYPE_DBE);

    // Counter only has to reach TIMEOUT_CYCLES-1; the final BUSY cycle is detected by compare
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [31:0]      addr_q;
    logic [4:0]       dest_q;

    logic        is_load, is_store, sz_byte, sz_half, sz_word;
    logic        is_mem, has_exc, misaligned, accept, start_access, timeout_hit, busy_load;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;

    logic             nxt_valid, nxt_wen;
    logic [4:0]       nxt_dest;
    logic [31:0]      nxt_result, nxt_bad;
    logic [EXC_W-1:0] nxt_exc;

    // Decode the incoming op: direction, access size, alignment, lane steering
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        case (mem_op)
            OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
            default:       ;
        endcase
        misaligned = (sz_half & alu_result[0]) | (sz_word & (alu_result[1:0] != 2'b00));
        if (sz_byte)
            be_in = 4'b0001 << alu_result[1:0];
        else if (sz_half)
            be_in = alu_result[1] ? 4'b1100 : 4'b0011;
        else
            be_in = 4'b1111;
        if (!is_store)
            wdata_in = 32'd0;
        else if (sz_byte)
            wdata_in = {4{store_data[7:0]}};
        else if (sz_half)
            wdata_in = {2{store_data[15:0]}};
        else
            wdata_in = store_data;
    end

    assign is_mem       = is_load | is_store;
    assign has_exc      = (exc_type_in != EXC_NONE);
    assign accept       = (state == S_IDLE) & in_valid & ~flush;
    assign start_access = accept & ~has_exc & is_mem & ~misaligned;
    assign timeout_hit  = (state == S_BUSY) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy_load    = (op_q >= OP_LB) && (op_q <= OP_LW);
    assign dmem_req     = (state == S_BUSY);
    assign dmem_addr    = {addr_q[31:2], 2'b00};

    // Pick the addressed lane of the returned word and extend it; stores report their address
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            OP_LB:   load_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_value = {24'd0, ld_byte};
            OP_LH:   load_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_value = {16'd0, ld_half};
            OP_LW:   load_value = dmem_rdata;
            default: load_value = addr_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state: leave BUSY on ack or timeout; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_access) state_nxt = S_BUSY;
            S_BUSY:  if (dmem_ack || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    // Outputs: stall request and the value to load into the MEM/WB register
    always_comb begin
        stall_req  = 1'b0;
        nxt_valid  = 1'b0;
        nxt_wen    = 1'b0;
        nxt_dest   = 5'd0;
        nxt_result = 32'd0;
        nxt_exc    = EXC_NONE;
        nxt_bad    = 32'd0;
        if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        nxt_dest   = dest_reg;
                        nxt_result = alu_result;
                        if (has_exc) begin
                            nxt_valid = 1'b1;
                            nxt_exc   = exc_type_in;
                        end else if (!is_mem) begin
                            nxt_valid = 1'b1;
                            nxt_wen   = (dest_reg != 5'd0);
                        end else if (misaligned) begin
                            nxt_valid = 1'b1;
                            nxt_exc   = is_load ? EXC_ADEL : EXC_ADES;
                            nxt_bad   = alu_result;
                        end else begin
                            stall_req = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    nxt_dest = dest_q;
                    if (dmem_ack) begin
                        nxt_valid  = 1'b1;
                        nxt_wen    = busy_load & (dest_q != 5'd0);
                        nxt_result = load_value;
                    end else if (timeout_hit) begin
                        nxt_valid  = 1'b1;
                        nxt_exc    = EXC_DBE;
                        nxt_bad    = addr_q;
                        nxt_result = addr_q;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout counter runs only while staying in BUSY
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == S_BUSY && state_nxt == S_BUSY)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Latch the access so the bus stays stable while BUSY
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= 4'd0;
            addr_q     <= 32'd0;
            dest_q     <= 5'd0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
        end else if (start_access) begin
            op_q       <= mem_op;
            addr_q     <= alu_result;
            dest_q     <= dest_reg;
            dmem_we    <= is_store;
            dmem_be    <= be_in;
            dmem_wdata <= wdata_in;
        end
    end

    // MEM/WB boundary register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_wen       <= 1'b0;
            out_dest      <= 5'd0;
            out_result    <= 32'd0;
            out_exc_type  <= EXC_NONE;
            out_bad_vaddr <= 32'd0;
        end else begin
            out_valid     <= nxt_valid;
            out_wen       <= nxt_wen;
            out_dest      <= nxt_dest;
            out_result    <= nxt_result;
            out_exc_type  <= nxt_exc;
            out_bad_vaddr <= nxt_bad;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
`ifndef EXC_TYPE_LENGTH
`define EXC_TYPE_LENGTH 5
`endif
`ifndef EXC_TYPE_NONE
`define EXC_TYPE_NONE 5'd0
`endif
`ifndef EXC_TYPE_ADEL
`define EXC_TYPE_ADEL 5'd4
`endif
`ifndef EXC_TYPE_ADES
`define EXC_TYPE_ADES 5'd5
`endif
`ifndef EXC_TYPE_DBE
`define EXC_TYPE_DBE 5'd7
`endif
`ifndef EXC_TYPE_OV
`define EXC_TYPE_OV 5'd12
`endif

module tb_mem_access_stage;
    localparam int EW = `EXC_TYPE_LENGTH;
    localparam logic [EW-1:0] X_NONE = `EXC_TYPE_NONE;
    localparam logic [EW-1:0] X_ADEL = `EXC_TYPE_ADEL;
    localparam logic [EW-1:0] X_ADES = `EXC_TYPE_ADES;
    localparam logic [EW-1:0] X_DBE  = `EXC_TYPE_DBE;
    localparam logic [EW-1:0] X_OV   = `EXC_TYPE_OV;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, dmem_ack = 1'b0;
    logic [3:0]    mem_op = 4'd0;
    logic [31:0]   alu_result = 32'd0, store_data = 32'd0, dmem_rdata = 32'd0;
    logic [4:0]    dest_reg = 5'd0;
    logic [EW-1:0] exc_type_in = X_NONE;
    logic          dmem_req, dmem_we, stall_req, out_valid, out_wen;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_addr, dmem_wdata, out_result, out_bad_vaddr;
    logic [4:0]    out_dest;
    logic [EW-1:0] out_exc_type;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .EXC_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .mem_op(mem_op),
        .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
        .exc_type_in(exc_type_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_req(stall_req), .out_valid(out_valid), .out_wen(out_wen),
        .out_dest(out_dest), .out_result(out_result), .out_exc_type(out_exc_type),
        .out_bad_vaddr(out_bad_vaddr)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes (0 = not a memory op)
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic [31:0] size_mask(input int sz);
        if (sz >= 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * sz)) - 32'd1;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz;
        logic [31:0] m, v;
        sz = op_size(op);
        m = size_mask(sz);
        v = (rdata >> (8 * (addr % 4))) & m;
        if ((op == 4'd1 || op == 4'd3) && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
        int sz;
        logic [3:0] b;
        sz = op_size(op);
        b = 4'((1 << sz) - 1);
        return 4'(b << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] sd);
        case (op_size(op))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // Aligned memory access; call at posedge+1 with the stage idle
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] dest, input logic [31:0] rdata, input int delay);
        logic [31:0] exp_res;
        bit exp_wen;
        in_valid = 1'b1; mem_op = op; alu_result = addr; store_data = sd; dest_reg = dest;
        exc_type_in = X_NONE;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL accept_stall: got %0b want 1", stall_req); end
        @(posedge clk); #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL busy_req: got %0b want 1", dmem_req); end
        checks++; if (dmem_we !== (op >= 4'd6)) begin errors++; $display("FAIL we op=%0d: got %0b want %0b", op, dmem_we, op >= 4'd6); end
        checks++; if (dmem_be !== model_be(op, addr)) begin errors++; $display("FAIL be op=%0d addr=%h: got %b want %b", op, addr, dmem_be, model_be(op, addr)); end
        checks++; if (dmem_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL addr: got %h want %h", dmem_addr, addr & 32'hFFFF_FFFC); end
        if (op >= 4'd6) begin
            checks++; if (dmem_wdata !== model_wdata(op, sd)) begin errors++; $display("FAIL wdata op=%0d: got %h want %h", op, dmem_wdata, model_wdata(op, sd)); end
        end
        for (int k = 1; k < delay; k++) begin
            checks++; if (stall_req !== 1'b1 || dmem_req !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL busy_wait k=%0d: stall=%0b req=%0b valid=%0b want 1 1 0", k, stall_req, dmem_req, out_valid);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL ack_stall: got %0b want 0", stall_req); end
        @(posedge clk); #1;
        dmem_ack = 1'b0; in_valid = 1'b0;
        exp_res = op_is_load(op) ? model_load(op, addr, rdata) : addr;
        exp_wen = op_is_load(op) && (dest != 5'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL done_valid: got %0b want 1", out_valid); end
        checks++; if (out_wen !== exp_wen) begin errors++; $display("FAIL done_wen op=%0d: got %0b want %0b", op, out_wen, exp_wen); end
        checks++; if (out_result !== exp_res) begin errors++; $display("FAIL done_result op=%0d addr=%h rdata=%h: got %h want %h", op, addr, rdata, out_result, exp_res); end
        checks++; if (out_exc_type !== X_NONE || dmem_req !== 1'b0) begin errors++; $display("FAIL done_exc_req: exc=%0d req=%0b want %0d 0", out_exc_type, dmem_req, X_NONE); end
        if (exp_wen) begin
            checks++; if (out_dest !== dest) begin errors++; $display("FAIL done_dest: got %0d want %0d", out_dest, dest); end
        end
    endtask

    // Single-cycle instruction (NONE op, misaligned, or upstream exception)
    task automatic run_pass(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] dest,
                            input logic [EW-1:0] exc);
        int sz;
        sz = op_size(op);
        in_valid = 1'b1; mem_op = op; alu_result = addr; dest_reg = dest; exc_type_in = exc;
        store_data = $urandom;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL pass_stall: got %0b want 0", stall_req); end
        @(posedge clk); #1;
        in_valid = 1'b0; exc_type_in = X_NONE;
        checks++; if (out_valid !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL pass_valid_req: valid=%0b req=%0b want 1 0", out_valid, dmem_req); end
        if (exc != X_NONE) begin
            checks++; if (out_exc_type !== exc || out_wen !== 1'b0) begin errors++; $display("FAIL pass_upstream_exc: exc=%0d wen=%0b want %0d 0", out_exc_type, out_wen, exc); end
        end else if (sz == 0) begin
            checks++; if (out_result !== addr || out_wen !== (dest != 5'd0) || out_exc_type !== X_NONE) begin
                errors++; $display("FAIL pass_none: result=%h wen=%0b exc=%0d want %h %0b %0d", out_result, out_wen, out_exc_type, addr, dest != 5'd0, X_NONE);
            end
            if (dest != 5'd0) begin
                checks++; if (out_dest !== dest) begin errors++; $display("FAIL pass_dest: got %0d want %0d", out_dest, dest); end
            end
        end else begin
            checks++; if (out_exc_type !== (op_is_load(op) ? X_ADEL : X_ADES) || out_bad_vaddr !== addr || out_wen !== 1'b0) begin
                errors++; $display("FAIL pass_misaligned op=%0d: exc=%0d bad=%h wen=%0b want %0d %h 0", op, out_exc_type, out_bad_vaddr, out_wen, op_is_load(op) ? X_ADEL : X_ADES, addr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall_req} !== '0) begin
            errors++; $display("FAIL reset_bus: req=%0b we=%0b be=%b addr=%h wdata=%h stall=%0b want all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall_req);
        end
        checks++; if ({out_valid, out_wen, out_dest, out_result, out_bad_vaddr} !== '0 || out_exc_type !== X_NONE) begin
            errors++; $display("FAIL reset_out: valid=%0b wen=%0b dest=%0d res=%h bad=%h exc=%0d want 0s exc %0d", out_valid, out_wen, out_dest, out_result, out_bad_vaddr, out_exc_type, X_NONE);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        run_pass(4'd0, 32'h0000_1234, 5'd5, X_NONE);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_one_shot: got %0b want 0", out_valid); end
        run_pass(4'd0, 32'hDEAD_BEEF, 5'd0, X_NONE);
        run_pass(4'd13, 32'h0000_0100, 5'd9, X_NONE);
    endtask

    task automatic test_load();
        run_mem(4'd1, 32'h0000_0103, 32'd0, 5'd7, 32'h80FF_FFFF, 3);
        run_mem(4'd2, 32'h0000_0103, 32'd0, 5'd7, 32'h80FF_FFFF, 3);
        run_mem(4'd3, 32'h0000_0102, 32'd0, 5'd3, 32'h8001_7FFF, 1);
        run_mem(4'd4, 32'h0000_0102, 32'd0, 5'd3, 32'h8001_7FFF, 2);
        run_mem(4'd5, 32'h0000_0100, 32'd0, 5'd0, 32'h1234_5678, 1);
    endtask

    task automatic test_store();
        run_mem(4'd7, 32'h0000_0202, 32'hABCD_1234, 5'd4, 32'd0, 2);
        run_mem(4'd6, 32'h0000_0201, 32'h0000_00A5, 5'd4, 32'd0, 1);
        run_mem(4'd8, 32'h0000_0204, 32'hCAFE_F00D, 5'd4, 32'd0, 4);
    endtask

    task automatic test_misaligned();
        run_pass(4'd5, 32'h0000_0101, 5'd2, X_NONE);
        run_pass(4'd8, 32'h0000_0102, 5'd2, X_NONE);
        run_pass(4'd3, 32'h0000_0103, 5'd2, X_NONE);
        run_pass(4'd5, 32'h0000_0100, 5'd2, X_OV);
    endtask

    task automatic test_timeout();
        in_valid = 1'b1; mem_op = 4'd8; alu_result = 32'h0000_0300; store_data = 32'h1111_2222;
        dest_reg = 5'd1; exc_type_in = X_NONE;
        @(posedge clk); #1;
        for (int k = 1; k <= TMO; k++) begin
            checks++; if (dmem_req !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL tmo_wait k=%0d: req=%0b valid=%0b want 1 0", k, dmem_req, out_valid); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_exc_type !== X_DBE || out_bad_vaddr !== 32'h0000_0300 || out_wen !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL tmo_done: valid=%0b exc=%0d bad=%h wen=%0b req=%0b want 1 %0d 00000300 0 0", out_valid, out_exc_type, out_bad_vaddr, out_wen, dmem_req, X_DBE);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL tmo_late_ack: valid=%0b req=%0b want 0 0", out_valid, dmem_req); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; mem_op = 4'd5; alu_result = 32'h0000_0400; dest_reg = 5'd6; exc_type_in = X_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy: req=%0b valid=%0b want 0 0", dmem_req, out_valid); end
        in_valid = 1'b1; mem_op = 4'd5; alu_result = 32'h0000_0404;
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        flush = 1'b0; dmem_ack = 1'b0;
        checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL flush_ack: req=%0b valid=%0b wen=%0b want 0 0 0", dmem_req, out_valid, out_wen); end
        run_mem(4'd5, 32'h0000_0408, 32'd0, 5'd6, 32'h0BAD_F00D, 6);
    endtask

    task automatic test_reset_mid_busy();
        in_valid = 1'b1; mem_op = 4'd7; alu_result = 32'h0000_0502; store_data = 32'h7777_8888;
        dest_reg = 5'd2; exc_type_in = X_NONE;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, stall_req, out_valid, out_wen, out_dest, out_result, out_bad_vaddr} !== '0 || out_exc_type !== X_NONE) begin
            errors++; $display("FAIL reset_mid_busy: req=%0b we=%0b be=%b addr=%h wdata=%h want all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]    op;
        logic [31:0]   addr;
        logic [4:0]    dest;
        logic [EW-1:0] exc;
        int            sz;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            dest = 5'($urandom_range(0, 31));
            exc = ($urandom_range(0, 4) == 0) ? X_OV : X_NONE;
            sz = op_size(op);
            if (exc == X_NONE && sz != 0 && (addr % sz) == 0)
                run_mem(op, addr, $urandom, dest, $urandom, $urandom_range(1, 6));
            else
                run_pass(op, addr, dest, exc);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipelined CPU, directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address, or as a passthrough value for non-memory ops.
- Checks alignment, drives a req/ack data-memory handshake, and extracts and sign/zero-extends load data.
- Registers everything into the MEM/WB boundary and stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for dmem_ack before raising a data bus error.
- EXC_W, `EXC_TYPE_LENGTH: exception-type field width (shared definitions header).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  exception/redirect flush; kills in-flight op
- in_valid  in  1  EX stage presents a valid instruction
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- alu_result  in  32  address (mem ops) or result (NONE)
- store_data  in  32  rt value for stores
- dest_reg  in  5  writeback register
- exc_type_in  in  EXC_W  exception already raised upstream
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables, little-endian
- dmem_addr  out  32  {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  load data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- stall_req  out  1  upstream must hold inputs stable
- out_valid  out  1  MEM/WB entry valid
- out_wen  out  1  register write enable
- out_dest  out  5  writeback register
- out_result  out  32  writeback value
- out_exc_type  out  EXC_W  exception for commit
- out_bad_vaddr  out  32  faulting address

Behaviour:
- Reset (rst_n=0 at posedge):
  - State IDLE; timeout counter 0.
  - All outputs 0, except out_exc_type = `EXC_TYPE_NONE.
  - dmem_req drops the same edge.
- States: IDLE, BUSY.
- Accept in IDLE when in_valid & !flush. Priority order:
  1. exc_type_in != NONE: no access; 1-cycle passthrough; out_exc_type=exc_type_in; out_wen=0.
  2. mem_op NONE: 1-cycle passthrough; out_result=alu_result; out_wen=(dest_reg!=0).
  3. Misaligned (half: addr[0]; word: addr[1:0]!=0): no access; out_exc_type=ADEL (loads) / ADES (stores); out_bad_vaddr=alu_result; out_wen=0.
  4. Otherwise: go to BUSY with dmem_req=1 registered.
    - Latch address, op, dest_reg, and lane-steered store data.
    - dmem_we/be/addr/wdata held constant in BUSY.
- Byte enables:
  - Byte ops: 1<<addr[1:0].
  - Half ops: addr[1] ? 4'b1100 : 4'b0011.
  - Word ops: 4'b1111.
- dmem_wdata:
  - SB: {4{byte}}.
  - SH: {2{half}}.
  - SW: data.
- stall_req (combinational):
  - In IDLE: 1 when case 4 is being accepted.
  - In BUSY: 1 until dmem_ack.
- BUSY, dmem_ack=1:
  - Next edge: IDLE, dmem_req=0, out_valid=1.
  - Loads: out_result = selected lane of dmem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU); out_wen=(dest!=0).
  - Stores: out_wen=0, out_result=address.
  - stall_req falls in the ack cycle, so upstream advances on that same edge.
- BUSY, no ack: counter increments each cycle.
  - On reaching TIMEOUT_CYCLES: IDLE, dmem_req=0, out_valid=1, out_wen=0, out_exc_type=`EXC_TYPE_DBE, out_bad_vaddr=address.
  - A late ack after timeout is ignored.
- out_valid=0 in every cycle without a completion.
- Passthrough latency: 1 cycle. Memory latency: ack cycle + 1.
- flush (any state), next edge:
  - IDLE, dmem_req=0, out_valid=0, counter 0.
  - Flush concurrent with ack: response discarded, no writeback. A store acked that cycle is already committed to memory.
- Back-to-back: a new instruction may be accepted in the cycle after completion. Never two requests outstanding.

Test Plan:
1. NONE op, alu_result=0x1234, dest=5 -> next cycle out_valid=1, out_wen=1, out_result=0x1234, no dmem_req, stall_req=0.
2. LB addr=0x103, ack after 3 cycles with rdata=0x80FFFFFF -> be=4'b1000; stall_req high 3 cycles; then out_result=0xFFFFFF80. LBU same -> 0x00000080.
3. SH addr=0x202, store_data=0xABCD1234 -> dmem_addr=0x200, be=4'b1100, wdata=0x12341234, we=1; completion out_wen=0.
4. LW addr=0x101 -> no dmem_req; out_exc_type=ADEL, out_bad_vaddr=0x101. SW addr=0x102 -> ADES. exc_type_in=OV with LW -> OV passed through, no request.
5. SW with no ack for TIMEOUT_CYCLES (set 8) -> after 8 BUSY cycles: out_exc_type=DBE, dmem_req=0; late ack ignored.
6. flush in 2nd BUSY cycle -> next cycle IDLE, dmem_req=0, out_valid=0. rst_n=0 mid-BUSY -> all outputs reset at next edge.
